// File: rtl/mc_controller_if.sv
// ----------------------------------------------------------------------------
// mc_controller_if
// Bundle between the multi-cycle datapath and its control FSM.
//
//   Datapath -> controller:
//     Opcode[5:0]   IR[31:26]
//     Funct[5:0]    IR[5:0]
//     Zero          ALU equality flag, meaningful in EXEC
//     DMReady       data-memory completion handshake
//   Controller -> datapath:
//     PCWE, IRWE, RegWE, DMWE                          write strobes
//     IsBr, Jump, JType, RegA3Sel, SaveRA, ALUBSel     selects
//     DatatoReg[1:0], EXTCtrl[1:0], ALUCtrl[7:0]       selects / ALU op
//     State[2:0]                                       current FSM state
//     InstrDone                                        one-cycle retire pulse
//
// Modports: master = datapath side, slave = controller side.
// ----------------------------------------------------------------------------
interface mc_controller_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       DMReady;

    logic       PCWE;
    logic       IRWE;
    logic       RegWE;
    logic       DMWE;
    logic       IsBr;
    logic       Jump;
    logic       JType;
    logic       RegA3Sel;
    logic       SaveRA;
    logic       ALUBSel;
    logic [1:0] DatatoReg;
    logic [1:0] EXTCtrl;
    logic [7:0] ALUCtrl;
    logic [2:0] State;
    logic       InstrDone;

    modport master (
        output Opcode, Funct, Zero, DMReady,
        input  PCWE, IRWE, RegWE, DMWE, IsBr, Jump, JType, RegA3Sel, SaveRA,
               ALUBSel, DatatoReg, EXTCtrl, ALUCtrl, State, InstrDone
    );

    modport slave (
        input  Opcode, Funct, Zero, DMReady,
        output PCWE, IRWE, RegWE, DMWE, IsBr, Jump, JType, RegA3Sel, SaveRA,
               ALUBSel, DatatoReg, EXTCtrl, ALUCtrl, State, InstrDone
    );
endinterface

// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
// Multi-cycle MIPS-subset control unit (addu, subu, ori, lui, lw, sw, beq,
// j, jal, jr, nop; anything else behaves as nop).
// State sequence: FETCH -> DECODE -> [EXEC -> [MEM] -> [WB]] -> FETCH.
// All outputs are combinational from the state register and the current
// instruction fields; the state register is the only storage.
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   asynchronous, active-low; forces FETCH and zeroes all outputs
//   bus    slave modport of mc_controller_if (decode inputs, control outputs)
//
// Configuration:
//   MC_MEMWAIT_EN  defined   -> MEM waits for DMReady=1
//                  undefined -> DMReady ignored, MEM lasts exactly one cycle
// ----------------------------------------------------------------------------
module mc_controller (
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.slave bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    localparam logic [7:0] ALU_NONE = 8'h00;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SUB  = 8'h02;
    localparam logic [7:0] ALU_OR   = 8'h04;
    localparam logic [7:0] ALU_LUI  = 8'h08;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    // Kept as plain logic so an out-of-range code (5-7) is representable.
    logic [2:0] state_q;
    logic [2:0] state_d;

    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq;
    logic is_j, is_jal, is_rtype, is_alu_wb, is_mem, is_jump;
    logic mem_ready;
    logic legal_state;

    assign is_addu   = (bus.Opcode == 6'h00) && (bus.Funct == 6'h21);
    assign is_subu   = (bus.Opcode == 6'h00) && (bus.Funct == 6'h23);
    assign is_jr     = (bus.Opcode == 6'h00) && (bus.Funct == 6'h08);
    assign is_ori    = (bus.Opcode == 6'h0D);
    assign is_lui    = (bus.Opcode == 6'h0F);
    assign is_lw     = (bus.Opcode == 6'h23);
    assign is_sw     = (bus.Opcode == 6'h2B);
    assign is_beq    = (bus.Opcode == 6'h04);
    assign is_j      = (bus.Opcode == 6'h02);
    assign is_jal    = (bus.Opcode == 6'h03);

    assign is_rtype  = is_addu | is_subu;
    assign is_alu_wb = is_rtype | is_ori | is_lui;
    assign is_mem    = is_lw | is_sw;
    assign is_jump   = is_j | is_jal | is_jr;

    assign legal_state = (state_q <= WB);

`ifdef MC_MEMWAIT_EN
    assign mem_ready = bus.DMReady;
`else
    // DMReady plays no part in this build; the sink only marks it as
    // intentionally unused.
    logic unused_dmready;
    assign unused_dmready = bus.DMReady;
    assign mem_ready      = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = (is_alu_wb | is_mem | is_beq) ? EXEC : FETCH;
            EXEC: begin
                if (is_mem)         state_d = MEM;
                else if (is_alu_wb) state_d = WB;
                else                state_d = FETCH;
            end
            MEM: begin
                if (!mem_ready)     state_d = MEM;
                else if (is_lw)     state_d = WB;
                else                state_d = FETCH;
            end
            WB:      state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        bus.PCWE      = 1'b0;
        bus.IRWE      = 1'b0;
        bus.RegWE     = 1'b0;
        bus.DMWE      = 1'b0;
        bus.IsBr      = 1'b0;
        bus.Jump      = 1'b0;
        bus.JType     = 1'b0;
        bus.RegA3Sel  = 1'b0;
        bus.SaveRA    = 1'b0;
        bus.ALUBSel   = 1'b0;
        bus.DatatoReg = 2'd0;
        bus.EXTCtrl   = EXT_ZERO;
        bus.ALUCtrl   = ALU_NONE;
        bus.InstrDone = 1'b0;
        bus.State     = state_q;

        // Reset gating covers the combinational path too, so FETCH's
        // PCWE/IRWE cannot leak out while reset is held low.
        if (reset) begin
            // ALU/extender selects follow the instruction from DECODE to WB.
            if (legal_state && (state_q != FETCH)) begin
                if (is_addu | is_lw | is_sw) bus.ALUCtrl = ALU_ADD;
                else if (is_subu | is_beq)   bus.ALUCtrl = ALU_SUB;
                else if (is_ori)             bus.ALUCtrl = ALU_OR;
                else if (is_lui)             bus.ALUCtrl = ALU_LUI;

                if (is_lw | is_sw | is_beq)  bus.EXTCtrl = EXT_SIGN;
                else if (is_lui)             bus.EXTCtrl = EXT_UPPER;

                bus.ALUBSel = is_ori | is_lui | is_mem;
            end

            case (state_q)
                FETCH: begin
                    bus.IRWE = 1'b1;
                    bus.PCWE = 1'b1;
                end
                DECODE: begin
                    if (is_jump) begin
                        bus.PCWE = 1'b1;
                        bus.Jump = 1'b1;
                    end
                    bus.JType = is_jr;
                    if (is_jal) begin
                        bus.RegWE     = 1'b1;
                        bus.SaveRA    = 1'b1;
                        bus.DatatoReg = 2'd2;
                    end
                end
                EXEC: begin
                    if (is_beq) begin
                        bus.IsBr = 1'b1;
                        bus.PCWE = bus.Zero;
                    end
                end
                MEM: begin
                    // Held for the whole wait so the memory sees a stable request.
                    bus.DMWE = is_sw;
                end
                WB: begin
                    bus.RegWE     = 1'b1;
                    bus.RegA3Sel  = is_rtype;
                    bus.DatatoReg = is_lw ? 2'd1 : 2'd0;
                end
                default: ;
            endcase

            // Retire in the last state of an instruction; FETCH and the
            // illegal-code recovery never retire anything.
            bus.InstrDone = legal_state && (state_q != FETCH) && (state_d == FETCH);
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MC_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    typedef struct packed {
        logic        rdy;
        logic [25:0] outs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {State, PCWE,IRWE,RegWE,DMWE, IsBr,Jump,JType,RegA3Sel,SaveRA,ALUBSel,
    //  DatatoReg, EXTCtrl, ALUCtrl, InstrDone}
    function automatic logic [25:0] observe();
        return {bus.State, bus.PCWE, bus.IRWE, bus.RegWE, bus.DMWE,
                bus.IsBr, bus.Jump, bus.JType, bus.RegA3Sel, bus.SaveRA, bus.ALUBSel,
                bus.DatatoReg, bus.EXTCtrl, bus.ALUCtrl, bus.InstrDone};
    endfunction

    function automatic logic [25:0] mk(input logic [2:0] st, input logic [3:0] strb,
                                       input logic [5:0] ctl, input logic [1:0] dtr,
                                       input logic [1:0] ext, input logic [7:0] alu,
                                       input logic done);
        return {st, strb, ctl, dtr, ext, alu, done};
    endfunction

    function automatic void push_rec(input logic rdy, input logic [25:0] outs);
        exp_t e;
        e.rdy  = rdy;
        e.outs = outs;
        sb_q.push_back(e);
    endfunction

    // Expected per-cycle trace of one instruction, starting in FETCH.
    function automatic void push_instr(input logic [5:0] op, input logic [5:0] fn,
                                       input logic zero, input int waits);
        bit         addu, subu, jr, ori, lui, lw, sw, beq, jj, jal, rtyp, alu_wb, mem;
        logic [7:0] alu;
        logic [1:0] ext;
        logic       bsel;
        logic [5:0] c;
        addu   = (op == 6'h00) && (fn == 6'h21);
        subu   = (op == 6'h00) && (fn == 6'h23);
        jr     = (op == 6'h00) && (fn == 6'h08);
        ori    = (op == 6'h0D);
        lui    = (op == 6'h0F);
        lw     = (op == 6'h23);
        sw     = (op == 6'h2B);
        beq    = (op == 6'h04);
        jj     = (op == 6'h02);
        jal    = (op == 6'h03);
        rtyp   = addu || subu;
        alu_wb = rtyp || ori || lui;
        mem    = lw || sw;
        alu    = (addu || lw || sw) ? 8'h01 : (subu || beq) ? 8'h02 :
                 ori ? 8'h04 : lui ? 8'h08 : 8'h00;
        ext    = (lw || sw || beq) ? 2'd1 : lui ? 2'd2 : 2'd0;
        bsel   = ori || lui || lw || sw;
        c      = {5'b0, bsel};

        push_rec(1'b1, mk(3'd0, 4'b1100, 6'd0, 2'd0, 2'd0, 8'h00, 1'b0));
        if (jj)       push_rec(1'b1, mk(3'd1, 4'b1000, 6'b010000, 2'd0, 2'd0, 8'h00, 1'b1));
        else if (jal) push_rec(1'b1, mk(3'd1, 4'b1010, 6'b010010, 2'd2, 2'd0, 8'h00, 1'b1));
        else if (jr)  push_rec(1'b1, mk(3'd1, 4'b1000, 6'b011000, 2'd0, 2'd0, 8'h00, 1'b1));
        else if (!(alu_wb || mem || beq))
                      push_rec(1'b1, mk(3'd1, 4'b0000, 6'd0, 2'd0, 2'd0, 8'h00, 1'b1));
        else begin
            push_rec(1'b1, mk(3'd1, 4'b0000, c, 2'd0, ext, alu, 1'b0));
            if (beq) begin
                push_rec(1'b1, mk(3'd2, {zero, 3'b000}, {1'b1, 4'b0, bsel}, 2'd0, ext, alu, 1'b1));
            end else begin
                push_rec(1'b1, mk(3'd2, 4'b0000, c, 2'd0, ext, alu, 1'b0));
                if (mem) begin
                    if (MEMWAIT) begin
                        for (int i = 0; i < waits; i++)
                            push_rec(1'b0, mk(3'd3, {3'b000, sw}, c, 2'd0, ext, alu, 1'b0));
                        push_rec(1'b1, mk(3'd3, {3'b000, sw}, c, 2'd0, ext, alu, sw));
                    end else begin
                        push_rec(waits == 0, mk(3'd3, {3'b000, sw}, c, 2'd0, ext, alu, sw));
                    end
                end
                if (!sw)
                    push_rec(1'b1, mk(3'd4, 4'b0010, {3'b000, rtyp, 1'b0, bsel},
                                      lw ? 2'd1 : 2'd0, ext, alu, 1'b1));
            end
        end
    endfunction

    // Entered at a falling edge with the DUT in FETCH; leaves at the falling
    // edge of the next FETCH, or right after an asynchronous reset if abort_at>0.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int waits, input int abort_at);
        exp_t e;
        int   cyc = 0;
        push_instr(op, fn, zero, waits);
        bus.Opcode = op;
        bus.Funct  = fn;
        bus.Zero   = zero;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.DMReady = e.rdy;
            #1;
            check_val($sformatf("%s_cyc%0d", tag, cyc), {6'd0, observe()}, {6'd0, e.outs});
            cyc++;
            if (abort_at > 0 && cyc == abort_at) begin
                reset = 1'b0;
                #1;
                check_val({tag, "_rst_async"}, {6'd0, observe()}, 32'd0);
                sb_q.delete();
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.Opcode  = 6'h00;
        bus.Funct   = 6'h00;
        bus.Zero    = 1'b0;
        bus.DMReady = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_val("reset_outs", {6'd0, observe()}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // sw stalled in MEM, then reset pulled low mid-cycle
        run_instr("sw_abort", 6'h2B, 6'h00, 1'b0, 3, 4);
        @(posedge clk);
        #1;
        check_val("reset_hold", {6'd0, observe()}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_instr("addu",     6'h00, 6'h21, 1'b0, 0, 0);
        run_instr("beq_z1",   6'h04, 6'h00, 1'b1, 0, 0);
        run_instr("beq_z0",   6'h04, 6'h00, 1'b0, 0, 0);
        run_instr("lw_wait",  6'h23, 6'h00, 1'b0, 3, 0);
        run_instr("jal",      6'h03, 6'h00, 1'b0, 0, 0);
        run_instr("jr",       6'h00, 6'h08, 1'b0, 0, 0);
        run_instr("j",        6'h02, 6'h00, 1'b0, 0, 0);
        run_instr("subu",     6'h00, 6'h23, 1'b0, 0, 0);
        run_instr("ori",      6'h0D, 6'h00, 1'b0, 0, 0);
        run_instr("lui",      6'h0F, 6'h00, 1'b0, 0, 0);
        run_instr("sw",       6'h2B, 6'h00, 1'b0, 0, 0);
        run_instr("sw_wait",  6'h2B, 6'h00, 1'b0, 2, 0);
        run_instr("lw",       6'h23, 6'h00, 1'b0, 0, 0);
        run_instr("nop",      6'h00, 6'h00, 1'b0, 0, 0);
        run_instr("undef_fn", 6'h00, 6'h3F, 1'b1, 0, 0);
        run_instr("undef_op", 6'h3F, 6'h00, 1'b0, 0, 0);

        // illegal state code recovers to FETCH with everything quiet
        force dut.state_q = 3'd7;
        #1;
        check_val("illegal_outs", {6'd0, observe()}, {6'd0, mk(3'd7, 4'b0, 6'd0, 2'd0, 2'd0, 8'h00, 1'b0)});
        release dut.state_q;
        @(posedge clk);
        #1;
        check_val("illegal_recover", {29'd0, bus.State}, 32'd0);
        @(negedge clk);

        run_instr("addu_after", 6'h00, 6'h21, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk: input, 1 bit, sole clock, rising edge.
REQ-003 Port reset: input, 1 bit, asynchronous, active-low (0 = reset).
REQ-004 Port Opcode: input, 6 bits, IR[31:26] from the datapath instruction register.
REQ-005 Port Funct: input, 6 bits, IR[5:0].
REQ-006 Port Zero: input, 1 bit, ALU equality flag, valid in EXEC.
REQ-007 Port DMReady: input, 1 bit, data-memory completion handshake.
REQ-008 Outputs SHALL be:
- PCWE, IRWE, RegWE, DMWE: 1 bit each, write strobes.
- IsBr, Jump, JType, RegA3Sel, SaveRA, ALUBSel: 1 bit each.
- DatatoReg: 2 bits.
- EXTCtrl: 2 bits.
- ALUCtrl: 8 bits.
- State: 3 bits, current FSM state.
- InstrDone: 1 bit, retire pulse.

Function
REQ-009 State encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge with all strobes 0.
REQ-010 The supported instruction set SHALL be addu, subu, ori, lui, lw, sw, beq, j, jal, jr and nop (all-zero word). Every other Opcode/Funct SHALL be treated as nop.
REQ-011 FETCH SHALL assert IRWE=1 and PCWE=1 (PC+4), then go to DECODE.
REQ-012 DECODE SHALL handle jumps and non-executing instructions:
- j: PCWE=1, Jump=1, JType=0 -> FETCH.
- jal: as j, plus RegWE=1, SaveRA=1, DatatoReg=2 -> FETCH.
- jr: PCWE=1, Jump=1, JType=1 -> FETCH.
- nop or undefined: no strobe -> FETCH.
- All other instructions: -> EXEC.
REQ-013 EXEC for beq SHALL assert IsBr=1, ALUCtrl=SUB and PCWE=Zero, then go to FETCH.
REQ-014 EXEC SHALL go to MEM for lw/sw and to WB for addu/subu/ori/lui.
REQ-015 MEM for sw SHALL assert DMWE=1 and go to FETCH when DMReady=1. MEM for lw SHALL hold DMWE=0 and go to WB when DMReady=1. MEM SHALL remain in MEM while DMReady=0, with DMWE held.
REQ-016 WB SHALL assert RegWE=1 with:
- R-type: RegA3Sel=1, DatatoReg=0.
- ori/lui: RegA3Sel=0, DatatoReg=0.
- lw: RegA3Sel=0, DatatoReg=1.
After WB the FSM SHALL go to FETCH.
REQ-017 ALUCtrl SHALL be 8'h01 ADD (addu/lw/sw), 8'h02 SUB (subu/beq), 8'h04 OR (ori) and 8'h08 LUI, and 8'h00 elsewhere.
REQ-018 EXTCtrl SHALL be 0 zero-extend (ori), 1 sign-extend (lw/sw/beq), 2 upper-shift (lui).
REQ-019 ALUBSel SHALL be 1 for ori/lui/lw/sw, else 0.
REQ-020 Non-strobe controls SHALL be driven in DECODE through WB and SHALL be 0 in FETCH. Strobes SHALL be asserted only in the states named above.
REQ-021 Outputs SHALL be combinational from State, Opcode, Funct, Zero and DMReady. The only storage SHALL be the State register.
REQ-022 InstrDone SHALL pulse for 1 cycle in the state whose next state is FETCH, excluding FETCH itself and illegal-state recovery.
REQ-023 Latency with DMReady=1 SHALL be: j/jal/jr/nop 2 cycles; beq 3; R-type, ori, lui and sw 4; lw 5.

Reset
REQ-024 reset=0 SHALL force State=FETCH immediately, independent of clk.
REQ-025 While reset=0, all outputs SHALL be 0, including IRWE and PCWE, which override FETCH decode.
REQ-026 Reset asserted mid-instruction SHALL abandon the instruction. No strobe SHALL fire after reset assertion.
REQ-027 The first rising edge after reset release SHALL execute FETCH.

Configuration
REQ-028 Macro MC_MEMWAIT_EN SHALL control the memory handshake:
- Defined: DMReady is honoured per REQ-015.
- Undefined: DMReady is ignored, MEM lasts exactly 1 cycle, and DMReady is left unconnected internally.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Reset and retire: reset=0 mid-MEM with sw, DMReady=0 -> State=0 and DMWE=0 at once. Release, then addu (Opcode 0, Funct 6'h21) -> states 0,1,2,4,0; RegWE=1 and RegA3Sel=1 only in WB; InstrDone=1 in WB.
- Branch: beq (Opcode 6'h04) with Zero=1 -> PCWE=1, IsBr=1, ALUCtrl=8'h02 in EXEC. With Zero=0 -> PCWE=0. Both take 3 cycles.
- Load wait: lw (6'h23), MC_MEMWAIT_EN defined, DMReady low for 3 cycles -> MEM held 4 cycles. WB then has DatatoReg=1, RegWE=1; total 8 cycles.
- Load without macro: same lw stimulus, macro undefined -> 5 cycles, DMReady ignored.
- Jumps: jal (6'h03) -> DECODE shows PCWE=1, Jump=1, RegWE=1, SaveRA=1, DatatoReg=2, then FETCH. jr (0/6'h08) -> JType=1.
- Undefined opcode: Opcode 6'h3F -> DECODE->FETCH, no strobe, InstrDone=1. Force State=7 -> FETCH next edge.
